// File: rtl/stor_pkg.sv
// stor_pkg: shared operation encoding and sizing helper for the data_storage blocks
package stor_pkg;

  typedef enum logic [2:0] {OP_HOLD, OP_CLR, OP_PUSH, OP_POP, OP_REPL} op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_d_en_stor_n.sv
// reg_d_en_stor_n: WIDTH-bit D register with async active-low reset, sync clear and load enable
module reg_d_en_stor_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // clear wins over load so a CLR cycle always leaves the word at zero
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (en_i) q_o <= d_i;

endmodule

// File: rtl/stack_stor_n.sv
// stack_stor_n: DEPTH x WIDTH LIFO with push, pop, replace-top, clear and sticky flags
module stack_stor_n
  import stor_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Z,
  output logic [CW-1:0]    COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVF,
  output logic             UNF
);

  op_e             op;
  logic [CW-1:0]   count_q, count_d, wr_idx;
  logic            ovf_q, ovf_d, unf_q, unf_d, wr;
  logic [WIDTH-1:0] word [DEPTH];

  assign FULL  = count_q == CW'(DEPTH);
  assign EMPTY = count_q == '0;
  assign COUNT = count_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

  // one operation per cycle; EN=0 decodes to hold so every register simply reloads itself
  always_comb
    op = !EN ? OP_HOLD : CLR ? OP_CLR : (PUSH && POP) ? OP_REPL :
         PUSH ? OP_PUSH : POP ? OP_POP : OP_HOLD;

  // occupancy, flags and write target; replace on an empty stack acts as a push
  always_comb begin
    count_d = op == OP_CLR ? '0 :
              ((op == OP_PUSH && !FULL) || (op == OP_REPL && EMPTY)) ? count_q + 1'b1 :
              (op == OP_POP && !EMPTY) ? count_q - 1'b1 : count_q;
    ovf_d   = op == OP_CLR ? 1'b0 : ovf_q | (op == OP_PUSH && FULL);
    unf_d   = op == OP_CLR ? 1'b0 : unf_q | (op == OP_POP && EMPTY);
    wr      = (op == OP_PUSH && !FULL) || op == OP_REPL;
    wr_idx  = (op == OP_REPL && !EMPTY) ? count_q - 1'b1 : count_q;
  end

  // count and sticky flag registers
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    reg_d_en_stor_n #(.WIDTH(WIDTH)) u_reg (
      .clk_i (CLK),
      .rst_ni(RST),
      .clr_i (op == OP_CLR),
      .en_i  (wr && wr_idx == CW'(g)),
      .d_i   (X),
      .q_o   (word[g])
    );
  end

  // top-of-stack select by comparison rather than indexing, so non-power-of-two DEPTH needs no range guard
  always_comb begin
    Z = '0;
    for (int i = 0; i < DEPTH; i++)
      if (count_q == CW'(i + 1)) Z = word[i];
  end

endmodule

// File: tb/tb_stack_stor_n.sv
// tb_stack_stor_n: checks an 8x8 and a 3x16 stack against queue-based LIFO models
module tb_stack_stor_n;

  logic        clk = 0, rst_n = 0, en = 0, clr = 0, push = 0, pop = 0;
  logic [15:0] x = '0;
  logic [7:0]  z8;
  logic [15:0] z3;
  logic [3:0]  c8;
  logic [1:0]  c3;
  logic        f8, e8, o8, u8, f3, e3, o3, u3;
  int          checks = 0, errors = 0;

  logic [7:0]  q8[$];
  logic [15:0] q3[$];
  logic        mo8 = 0, mu8 = 0, mo3 = 0, mu3 = 0;

  always #5 clk = ~clk;

  stack_stor_n #(.WIDTH(8), .DEPTH(8)) d8 (
    .CLK(clk), .RST(rst_n), .EN(en), .CLR(clr), .PUSH(push), .POP(pop), .X(x[7:0]),
    .Z(z8), .COUNT(c8), .FULL(f8), .EMPTY(e8), .OVF(o8), .UNF(u8));

  stack_stor_n #(.WIDTH(16), .DEPTH(3)) d3 (
    .CLK(clk), .RST(rst_n), .EN(en), .CLR(clr), .PUSH(push), .POP(pop), .X(x),
    .Z(z3), .COUNT(c3), .FULL(f3), .EMPTY(e3), .OVF(o3), .UNF(u3));

  function automatic logic [7:0] ez8();
    return q8.size() ? q8[q8.size()-1] : 8'h00;
  endfunction

  function automatic logic [15:0] ez3();
    return q3.size() ? q3[q3.size()-1] : 16'h0000;
  endfunction

  function automatic void model_reset();
    q8 = {};
    q3 = {};
    mo8 = 0; mu8 = 0; mo3 = 0; mu3 = 0;
  endfunction

  task automatic cyc(input logic e, input logic c, input logic pu, input logic po, input logic [15:0] d);
    en = e; clr = c; push = pu; pop = po; x = d;
    @(posedge clk);
    if (e) begin
      if (c) model_reset();
      else if (pu && po) begin
        if (q8.size()) q8[q8.size()-1] = d[7:0]; else q8.push_back(d[7:0]);
        if (q3.size()) q3[q3.size()-1] = d; else q3.push_back(d);
      end else if (pu) begin
        if (q8.size() < 8) q8.push_back(d[7:0]); else mo8 = 1;
        if (q3.size() < 3) q3.push_back(d); else mo3 = 1;
      end else if (po) begin
        if (q8.size()) void'(q8.pop_back()); else mu8 = 1;
        if (q3.size()) void'(q3.pop_back()); else mu3 = 1;
      end
    end
    #1;
    en = 0; clr = 0; push = 0; pop = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    checks++;
    if ({z8, c8, f8, e8, o8, u8} !== {8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset8 got z=%h c=%0d f=%b e=%b o=%b u=%b want z=00 c=0 f=0 e=1 o=0 u=0", z8, c8, f8, e8, o8, u8);
    end
    checks++;
    if ({z3, c3, f3, e3, o3, u3} !== {16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset3 got z=%h c=%0d f=%b e=%b o=%b u=%b want z=0000 c=0 f=0 e=1 o=0 u=0", z3, c3, f3, e3, o3, u3);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_z [3];
    exp_z[0] = 8'h22; exp_z[1] = 8'h11; exp_z[2] = 8'h00;
    cyc(1, 0, 1, 0, 16'h11);
    cyc(1, 0, 1, 0, 16'h22);
    cyc(1, 0, 1, 0, 16'h33);
    checks++;
    if ({z8, c8, e8} !== {8'h33, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL push3 got z=%h c=%0d e=%b want z=33 c=3 e=0", z8, c8, e8);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 16'h0);
      checks++;
      if (z8 !== exp_z[i]) begin
        errors++;
        $display("FAIL pop%0d got z=%h want %h", i, z8, exp_z[i]);
      end
    end
    checks++;
    if (e8 !== 1'b1 || c8 !== 4'd0) begin
      errors++;
      $display("FAIL pop_empty got e=%b c=%0d want e=1 c=0", e8, c8);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) cyc(1, 0, 1, 0, 16'(i));
    checks++;
    if (f8 !== 1'b1 || o8 !== 1'b0) begin
      errors++;
      $display("FAIL full got f=%b o=%b want f=1 o=0", f8, o8);
    end
    checks++;
    if (o3 !== mo3 || c3 !== 2'd3 || z3 !== 16'h0003) begin
      errors++;
      $display("FAIL ovf3 got o=%b c=%0d z=%h want o=%b c=3 z=0003", o3, c3, z3, mo3);
    end
    cyc(1, 0, 1, 0, 16'hAA);
    checks++;
    if ({o8, c8, z8} !== {1'b1, 4'd8, 8'h08}) begin
      errors++;
      $display("FAIL ovf got o=%b c=%0d z=%h want o=1 c=8 z=08", o8, c8, z8);
    end
    cyc(1, 0, 1, 1, 16'hBB);
    checks++;
    if ({z8, o8, c8} !== {8'hBB, 1'b1, 4'd8}) begin
      errors++;
      $display("FAIL repl_full got z=%h o=%b c=%0d want z=bb o=1 c=8", z8, o8, c8);
    end
  endtask

  task automatic test_underflow();
    cyc(1, 1, 0, 0, 16'h0);
    cyc(1, 0, 0, 1, 16'h0);
    checks++;
    if (u8 !== 1'b1 || c8 !== 4'd0 || u3 !== 1'b1) begin
      errors++;
      $display("FAIL unf got u8=%b c=%0d u3=%b want u8=1 c=0 u3=1", u8, c8, u3);
    end
    cyc(1, 0, 1, 1, 16'h5C);
    checks++;
    if ({c8, z8, u8} !== {4'd1, 8'h5C, 1'b1}) begin
      errors++;
      $display("FAIL repl_empty got c=%0d z=%h u=%b want c=1 z=5c u=1", c8, z8, u8);
    end
    cyc(1, 1, 1, 1, 16'hFF);
    checks++;
    if ({c8, o8, u8, z8, e8} !== {4'd0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL clr got c=%0d o=%b u=%b z=%h e=%b want c=0 o=0 u=0 z=00 e=1", c8, o8, u8, z8, e8);
    end
  endtask

  task automatic test_enable();
    cyc(1, 0, 0, 1, 16'h0);
    cyc(1, 0, 1, 0, 16'h7E);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      checks++;
      if ({z8, c8, o8, u8} !== {8'h7E, 4'd1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold%0d got z=%h c=%0d o=%b u=%b want z=7e c=1 o=0 u=1", i, z8, c8, o8, u8);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 16'(8'h40 + i));
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({z8, c8, e8, o8, u8} !== {8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_rst got z=%h c=%0d e=%b o=%b u=%b want z=00 c=0 e=1 o=0 u=0", z8, c8, e8, o8, u8);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 0, 1, 16'h0);
    checks++;
    if (u8 !== 1'b1 || c8 !== 4'd0) begin
      errors++;
      $display("FAIL rst_pop got u=%b c=%0d want u=1 c=0", u8, c8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    cyc(1, 1, 0, 0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      w = (i % 4 == 0) ? 16'hBEEF : 16'h1234;
      cyc(1, 0, i % 2 == 0, i % 2 == 1, w);
      checks++;
      if (i % 2 == 0 ? ({z3, c3} !== {w, 2'd1}) : ({z3, c3} !== {16'h0000, 2'd0})) begin
        errors++;
        $display("FAIL alt%0d got z=%h c=%0d", i, z3, c3);
      end
      checks++;
      if ({o3, u3, f3} !== 3'b000) begin
        errors++;
        $display("FAIL alt_flags%0d got o=%b u=%b f=%b want 000", i, o3, u3, f3);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 1'($urandom), 1'($urandom), 16'($urandom));
      checks++;
      if ({z8, c8, f8, e8, o8, u8} !== {ez8(), 4'(q8.size()), q8.size() == 8, q8.size() == 0, mo8, mu8}) begin
        errors++;
        $display("FAIL rand8 #%0d got z=%h c=%0d f=%b e=%b o=%b u=%b want z=%h c=%0d o=%b u=%b",
                 i, z8, c8, f8, e8, o8, u8, ez8(), q8.size(), mo8, mu8);
      end
      checks++;
      if ({z3, c3, f3, e3, o3, u3} !== {ez3(), 2'(q3.size()), q3.size() == 3, q3.size() == 0, mo3, mu3}) begin
        errors++;
        $display("FAIL rand3 #%0d got z=%h c=%0d f=%b e=%b o=%b u=%b want z=%h c=%0d o=%b u=%b",
                 i, z3, c3, f3, e3, o3, u3, ez3(), q3.size(), mo3, mu3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_enable();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
